// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver: FSM state encoding,
// default oversampling rate, frame width and a counter-width helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_e;

  localparam int OS_RATE_DEFAULT = 16;
  localparam int DATA_BITS       = 8;

  // Bits needed to count 0 .. (os_rate * stop_bits - 1), never less than one.
  function automatic int cnt_width(input int os_rate, input int stop_bits);
    int span;
    span = os_rate * stop_bits;
    return (span < 2) ? 1 : $clog2(span);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-level handshake between a producer and the UART transmitter.
interface uart_tx_if;
  import uart_pkg::*;

  logic                 tx_start;
  logic [DATA_BITS-1:0] data_in;
  logic                 tx_ready;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (
    output tx_start, data_in,
    input  tx_ready, tx_busy, tx_done
  );

  modport slave (
    input  tx_start, data_in,
    output tx_ready, tx_busy, tx_done
  );

endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one-entry holding register feeding an LSB-first
// serialiser paced by the shared 16x baud-tick enable clk_out2.
module uart_tx
  import uart_pkg::*;
#(
  parameter int OS_RATE   = OS_RATE_DEFAULT,
  parameter int STOP_BITS = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      clk_out2,
  uart_tx_if.slave  bus,
  output logic      tx
);

  localparam int CW = cnt_width(OS_RATE, STOP_BITS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(OS_RATE - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * OS_RATE - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  uart_state_e          state, state_n;
  logic                 tx_n;
  logic                 hold_valid, hold_valid_n;
  logic [DATA_BITS-1:0] hold, hold_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [CW-1:0]        samp_cnt, samp_cnt_n;
  logic [2:0]           bit_pos, bit_pos_n;
  logic                 tx_done, tx_done_n;

  assign bus.tx_ready = !hold_valid;
  assign bus.tx_busy  = (state != IDLE);
  assign bus.tx_done  = tx_done;

  // NOTE: every variable gets its hold value first, so no path through this
  // block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_n      = state;
    tx_n         = tx;
    hold_valid_n = hold_valid;
    hold_n       = hold;
    shift_n      = shift;
    samp_cnt_n   = samp_cnt;
    bit_pos_n    = bit_pos;
    tx_done_n    = 1'b0;

    // Accepting and handing over are mutually exclusive: one needs an empty
    // holding register, the other a full one.
    if (bus.tx_start && !hold_valid) begin
      hold_n       = bus.data_in;
      hold_valid_n = 1'b1;
    end

    if (clk_out2) begin
      unique case (state)
        IDLE: begin
          if (hold_valid) begin
            state_n      = START;
            tx_n         = 1'b0;
            shift_n      = hold;
            hold_valid_n = 1'b0;
            samp_cnt_n   = '0;
          end
        end

        START: begin
          if (samp_cnt == BIT_LAST) begin
            state_n    = DATA;
            tx_n       = shift[0];
            bit_pos_n  = '0;
            samp_cnt_n = '0;
          end else begin
            samp_cnt_n = samp_cnt + 1'b1;
          end
        end

        DATA: begin
          if (samp_cnt == BIT_LAST) begin
            samp_cnt_n = '0;
            if (bit_pos == LAST_BIT) begin
              state_n = STOP;
              tx_n    = 1'b1;
            end else begin
              bit_pos_n = bit_pos + 3'd1;
              tx_n      = shift[bit_pos + 3'd1];
            end
          end else begin
            samp_cnt_n = samp_cnt + 1'b1;
          end
        end

        STOP: begin
          if (samp_cnt == STOP_LAST) begin
            tx_done_n  = 1'b1;
            samp_cnt_n = '0;
            // A waiting byte starts on this very tick: no idle gap between frames.
            if (hold_valid) begin
              state_n      = START;
              tx_n         = 1'b0;
              shift_n      = hold;
              hold_valid_n = 1'b0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            samp_cnt_n = samp_cnt + 1'b1;
          end
        end

        default: state_n = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      hold_valid <= 1'b0;
      samp_cnt   <= '0;
      bit_pos    <= '0;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_n;
      tx         <= tx_n;
      hold_valid <= hold_valid_n;
      samp_cnt   <= samp_cnt_n;
      bit_pos    <= bit_pos_n;
      tx_done    <= tx_done_n;
    end
  end

  // NOTE: hold and shift are pure datapath, only read while hold_valid or the
  // FSM qualifies them, so they carry no reset.
  always_ff @(posedge clk) begin
    hold  <= hold_n;
    shift <= shift_n;
  end

endmodule
